// File: rtl/netwalk_dpl_pkg.sv
// Shared widths, field indices/lengths and FSM encoding for the header deparser.
// The field index order is also the rewrite priority: a higher index lands later and wins on overlap.
package netwalk_dpl_pkg;

    localparam int HDR_BITS       = 512;
    localparam int HDR_BYTES      = 64;
    localparam int OFF_W          = 9;
    localparam int NUM_FIELDS     = 8;
    localparam int SLOT_W         = 48;
    localparam int IPV4_WORDS     = 10;
    localparam int IPV4_CSUM_WORD = 5;
    localparam int IPV4_CSUM_BYTE = 10;
    localparam int IPV4_MAX_OFF   = HDR_BYTES - 2 * IPV4_WORDS;

    localparam logic [2:0] FLD_DST_MAC  = 3'd0;
    localparam logic [2:0] FLD_SRC_MAC  = 3'd1;
    localparam logic [2:0] FLD_VLAN_ID  = 3'd2;
    localparam logic [2:0] FLD_TOS      = 3'd3;
    localparam logic [2:0] FLD_SRC_IPV4 = 3'd4;
    localparam logic [2:0] FLD_DST_IPV4 = 3'd5;
    localparam logic [2:0] FLD_TCP_SRC  = 3'd6;
    localparam logic [2:0] FLD_TCP_DST  = 3'd7;

    localparam logic [3:0] LEN_MAC  = 4'd6;
    localparam logic [3:0] LEN_VLAN = 4'd2;
    localparam logic [3:0] LEN_TOS  = 4'd1;
    localparam logic [3:0] LEN_IPV4 = 4'd4;
    localparam logic [3:0] LEN_PORT = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PATCH = 3'd1,
        ST_CSUM  = 3'd2,
        ST_FINAL = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    // Number of header bytes touched by a field (VLAN and TOS are partial but span whole bytes).
    function automatic logic [3:0] field_len(input logic [2:0] fld);
        case (fld)
            FLD_DST_MAC, FLD_SRC_MAC:   field_len = LEN_MAC;
            FLD_VLAN_ID:                field_len = LEN_VLAN;
            FLD_TOS:                    field_len = LEN_TOS;
            FLD_SRC_IPV4, FLD_DST_IPV4: field_len = LEN_IPV4;
            default:                    field_len = LEN_PORT;
        endcase
    endfunction

endpackage

// File: rtl/netwalk_ipv4_csum.sv
// Ones-complement accumulator for the IPv4 header checksum.
// The carry is folded back on every add, so the 17-bit register never overflows.
module netwalk_ipv4_csum (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        add,
    input  logic [15:0] word,
    output logic [15:0] csum
);

    logic [16:0] acc;
    logic [16:0] fold;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (add) begin
            acc <= {1'b0, acc[15:0]} + {1'b0, word} + {16'b0, acc[16]};
        end
    end

    // Two folds: 0x1FFFF folds to 0x10000 on the first pass.
    always_comb begin
        fold = {1'b0, acc[15:0]} + {16'b0, acc[16]};
        csum = ~(fold[15:0] + {15'b0, fold[16]});
    end

endmodule

// File: rtl/netwalk_header_deparser.sv
// Rewrites up to eight OpenFlow fields into a 64-byte header, optionally recomputes the
// IPv4 checksum over the patched bytes, and holds the result until downstream accepts it.
module netwalk_header_deparser
    import netwalk_dpl_pkg::*;
#(
    parameter int DPL_PKT_BIT_WIDTH   = HDR_BITS,
    parameter int DPL_PKT_BYTE_WIDTH  = HDR_BYTES,
    parameter int PKT_BUFF_ADDR_WIDTH = OFF_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pkt_header_ready,
    output logic                           pkt_header_accept,
    input  logic [DPL_PKT_BIT_WIDTH-1:0]   pkt_header_in,
    input  logic [7:0]                     of_mod_mask,
    input  logic [47:0]                    OF_DST_MAC_ADDR,
    input  logic [47:0]                    OF_SRC_MAC_ADDR,
    input  logic [11:0]                    OF_VLAN_ID,
    input  logic [5:0]                     OF_IPV4_TOS,
    input  logic [31:0]                    OF_SRC_IPV4_ADDR,
    input  logic [31:0]                    OF_DST_IPV4_ADDR,
    input  logic [15:0]                    OF_TCP_SRC_PORT,
    input  logic [15:0]                    OF_TCP_DST_PORT,
    input  logic [PKT_BUFF_ADDR_WIDTH-1:0] DST_MAC_ADDR_ADDR,
    input  logic [PKT_BUFF_ADDR_WIDTH-1:0] SRC_MAC_ADDR_ADDR,
    input  logic [PKT_BUFF_ADDR_WIDTH-1:0] VLAN_ID_ADDR,
    input  logic [PKT_BUFF_ADDR_WIDTH-1:0] IPV4_TOS_ADDR,
    input  logic [PKT_BUFF_ADDR_WIDTH-1:0] SRC_IPV4_ADDR_ADDR,
    input  logic [PKT_BUFF_ADDR_WIDTH-1:0] DST_IPV4_ADDR_ADDR,
    input  logic [PKT_BUFF_ADDR_WIDTH-1:0] TCP_SRC_PORT_ADDR,
    input  logic [PKT_BUFF_ADDR_WIDTH-1:0] TCP_DST_PORT_ADDR,
    input  logic [PKT_BUFF_ADDR_WIDTH-1:0] ip_hdr_offset,
    input  logic                           csum_en,
    output logic [DPL_PKT_BIT_WIDTH-1:0]   pkt_header_out,
    output logic                           pkt_out_valid,
    input  logic                           pkt_out_accept,
    output logic [7:0]                     deparse_err,
    output logic                           csum_err
);

    localparam int BIT_IDX_W  = $clog2(DPL_PKT_BIT_WIDTH);
    localparam int BYTE_IDX_W = $clog2(DPL_PKT_BYTE_WIDTH);

    state_t state, state_next;

    logic [DPL_PKT_BIT_WIDTH-1:0]   hdr;
    logic [3:0]                     idx;
    logic [7:0]                     derr_r;
    logic                           cerr_r;

    logic [7:0]                     mask_r;
    logic [47:0]                    dst_mac_r, src_mac_r;
    logic [11:0]                    vlan_r;
    logic [5:0]                     tos_r;
    logic [31:0]                    src_ip_r, dst_ip_r;
    logic [15:0]                    sport_r, dport_r;
    logic [PKT_BUFF_ADDR_WIDTH-1:0] off_r [NUM_FIELDS];
    logic [PKT_BUFF_ADDR_WIDTH-1:0] ip_off_r;
    logic                           csum_en_r;

    logic                           take;
    logic [2:0]                     fld;
    logic [SLOT_W-1:0]              slot_val, slot_wm;
    logic [PKT_BUFF_ADDR_WIDTH-1:0] slot_off;
    logic [PKT_BUFF_ADDR_WIDTH:0]   fld_end;
    logic                           fld_fits;
    logic                           ip_fits;
    logic [BYTE_IDX_W-1:0]          rd_byte;
    logic [BIT_IDX_W-1:0]           rd_lsb;
    logic [15:0]                    csum_word;
    logic [15:0]                    csum_val;

    // Merge a left-aligned 48-bit slot into the header at a byte offset; wm selects the bits replaced.
    function automatic logic [DPL_PKT_BIT_WIDTH-1:0] insert_bytes(
        input logic [DPL_PKT_BIT_WIDTH-1:0]   base,
        input logic [SLOT_W-1:0]              val,
        input logic [SLOT_W-1:0]              wm,
        input logic [PKT_BUFF_ADDR_WIDTH-1:0] off
    );
        logic [DPL_PKT_BIT_WIDTH-1:0] v;
        logic [DPL_PKT_BIT_WIDTH-1:0] m;
        v = {val, {(DPL_PKT_BIT_WIDTH-SLOT_W){1'b0}}} >> {off, 3'b000};
        m = {wm,  {(DPL_PKT_BIT_WIDTH-SLOT_W){1'b0}}} >> {off, 3'b000};
        return (base & ~m) | (v & m);
    endfunction

    assign take    = (state == ST_IDLE) && pkt_header_ready;
    assign fld     = idx[2:0];
    assign ip_fits = ip_off_r <= PKT_BUFF_ADDR_WIDTH'(IPV4_MAX_OFF);

    always_comb begin
        slot_val = '0;
        slot_wm  = '0;
        slot_off = off_r[fld];
        case (fld)
            FLD_DST_MAC: begin
                slot_val = dst_mac_r;
                slot_wm  = '1;
            end
            FLD_SRC_MAC: begin
                slot_val = src_mac_r;
                slot_wm  = '1;
            end
            // PCP/CFI occupy the top nibble of the TCI and are preserved.
            FLD_VLAN_ID: begin
                slot_val = {4'h0, vlan_r, 32'h0};
                slot_wm  = {16'h0FFF, 32'h0};
            end
            // ECN occupies the two low bits of the byte and is preserved.
            FLD_TOS: begin
                slot_val = {tos_r, 42'h0};
                slot_wm  = {8'hFC, 40'h0};
            end
            FLD_SRC_IPV4: begin
                slot_val = {src_ip_r, 16'h0};
                slot_wm  = {32'hFFFF_FFFF, 16'h0};
            end
            FLD_DST_IPV4: begin
                slot_val = {dst_ip_r, 16'h0};
                slot_wm  = {32'hFFFF_FFFF, 16'h0};
            end
            FLD_TCP_SRC: begin
                slot_val = {sport_r, 32'h0};
                slot_wm  = {16'hFFFF, 32'h0};
            end
            default: begin
                slot_val = {dport_r, 32'h0};
                slot_wm  = {16'hFFFF, 32'h0};
            end
        endcase
        fld_end  = {1'b0, slot_off} + (PKT_BUFF_ADDR_WIDTH+1)'(field_len(fld));
        fld_fits = fld_end <= (PKT_BUFF_ADDR_WIDTH+1)'(DPL_PKT_BYTE_WIDTH);
    end

    // The checksum word slot reads as zero so a stale checksum does not pollute the sum.
    always_comb begin
        rd_byte   = BYTE_IDX_W'(ip_off_r) + BYTE_IDX_W'({idx, 1'b0});
        rd_lsb    = BIT_IDX_W'(DPL_PKT_BIT_WIDTH - 16) - BIT_IDX_W'({rd_byte, 3'b000});
        csum_word = (idx == 4'(IPV4_CSUM_WORD)) ? 16'h0 : hdr[rd_lsb +: 16];
    end

    netwalk_ipv4_csum u_csum (
        .clk   (clk),
        .reset (reset),
        .clr   (take),
        .add   (state == ST_CSUM),
        .word  (csum_word),
        .csum  (csum_val)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pkt_header_ready) state_next = ST_PATCH;
            end
            ST_PATCH: begin
                if (idx == 4'(NUM_FIELDS - 1)) begin
                    state_next = (csum_en_r && ip_fits) ? ST_CSUM : ST_OUT;
                end
            end
            ST_CSUM: begin
                if (idx == 4'(IPV4_WORDS - 1)) state_next = ST_FINAL;
            end
            ST_FINAL: state_next = ST_OUT;
            ST_OUT: begin
                if (pkt_out_accept) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pkt_header_accept = (state == ST_IDLE);
        pkt_out_valid     = (state == ST_OUT);
        pkt_header_out    = hdr;
        deparse_err       = derr_r;
        csum_err          = cerr_r;
    end

    // Captured request fields only matter while a header is in flight, so they carry no reset.
    always_ff @(posedge clk) begin
        if (take) begin
            mask_r    <= of_mod_mask;
            dst_mac_r <= OF_DST_MAC_ADDR;
            src_mac_r <= OF_SRC_MAC_ADDR;
            vlan_r    <= OF_VLAN_ID;
            tos_r     <= OF_IPV4_TOS;
            src_ip_r  <= OF_SRC_IPV4_ADDR;
            dst_ip_r  <= OF_DST_IPV4_ADDR;
            sport_r   <= OF_TCP_SRC_PORT;
            dport_r   <= OF_TCP_DST_PORT;
            off_r[0]  <= DST_MAC_ADDR_ADDR;
            off_r[1]  <= SRC_MAC_ADDR_ADDR;
            off_r[2]  <= VLAN_ID_ADDR;
            off_r[3]  <= IPV4_TOS_ADDR;
            off_r[4]  <= SRC_IPV4_ADDR_ADDR;
            off_r[5]  <= DST_IPV4_ADDR_ADDR;
            off_r[6]  <= TCP_SRC_PORT_ADDR;
            off_r[7]  <= TCP_DST_PORT_ADDR;
            ip_off_r  <= ip_hdr_offset;
            csum_en_r <= csum_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr    <= '0;
            idx    <= '0;
            derr_r <= '0;
            cerr_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pkt_header_ready) begin
                        hdr    <= pkt_header_in;
                        idx    <= '0;
                        derr_r <= '0;
                        cerr_r <= 1'b0;
                    end
                end
                ST_PATCH: begin
                    if (mask_r[fld]) begin
                        if (fld_fits) hdr <= insert_bytes(hdr, slot_val, slot_wm, slot_off);
                        else          derr_r[fld] <= 1'b1;
                    end
                    if (idx == 4'(NUM_FIELDS - 1)) begin
                        idx    <= '0;
                        cerr_r <= csum_en_r && !ip_fits;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                ST_CSUM: begin
                    idx <= (idx == 4'(IPV4_WORDS - 1)) ? 4'd0 : idx + 4'd1;
                end
                ST_FINAL: begin
                    hdr <= insert_bytes(hdr, {csum_val, 32'h0}, {16'hFFFF, 32'h0},
                                        ip_off_r + PKT_BUFF_ADDR_WIDTH'(IPV4_CSUM_BYTE));
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_netwalk_header_deparser.sv
// Directed-vector bench for the header deparser: a table of requests with hand-built expected
// headers, plus hand-written stall and mid-checksum reset sequences.
module tb_netwalk_header_deparser;

    logic         clk = 1'b0;
    logic         reset;
    logic         pkt_header_ready;
    logic         pkt_header_accept;
    logic [511:0] pkt_header_in;
    logic [7:0]   of_mod_mask;
    logic [47:0]  OF_DST_MAC_ADDR, OF_SRC_MAC_ADDR;
    logic [11:0]  OF_VLAN_ID;
    logic [5:0]   OF_IPV4_TOS;
    logic [31:0]  OF_SRC_IPV4_ADDR, OF_DST_IPV4_ADDR;
    logic [15:0]  OF_TCP_SRC_PORT, OF_TCP_DST_PORT;
    logic [8:0]   DST_MAC_ADDR_ADDR, SRC_MAC_ADDR_ADDR, VLAN_ID_ADDR, IPV4_TOS_ADDR;
    logic [8:0]   SRC_IPV4_ADDR_ADDR, DST_IPV4_ADDR_ADDR, TCP_SRC_PORT_ADDR, TCP_DST_PORT_ADDR;
    logic [8:0]   ip_hdr_offset;
    logic         csum_en;
    logic [511:0] pkt_header_out;
    logic         pkt_out_valid;
    logic         pkt_out_accept;
    logic [7:0]   deparse_err;
    logic         csum_err;

    always #5 clk = ~clk;

    netwalk_header_deparser dut (
        .clk(clk), .reset(reset),
        .pkt_header_ready(pkt_header_ready), .pkt_header_accept(pkt_header_accept),
        .pkt_header_in(pkt_header_in), .of_mod_mask(of_mod_mask),
        .OF_DST_MAC_ADDR(OF_DST_MAC_ADDR), .OF_SRC_MAC_ADDR(OF_SRC_MAC_ADDR),
        .OF_VLAN_ID(OF_VLAN_ID), .OF_IPV4_TOS(OF_IPV4_TOS),
        .OF_SRC_IPV4_ADDR(OF_SRC_IPV4_ADDR), .OF_DST_IPV4_ADDR(OF_DST_IPV4_ADDR),
        .OF_TCP_SRC_PORT(OF_TCP_SRC_PORT), .OF_TCP_DST_PORT(OF_TCP_DST_PORT),
        .DST_MAC_ADDR_ADDR(DST_MAC_ADDR_ADDR), .SRC_MAC_ADDR_ADDR(SRC_MAC_ADDR_ADDR),
        .VLAN_ID_ADDR(VLAN_ID_ADDR), .IPV4_TOS_ADDR(IPV4_TOS_ADDR),
        .SRC_IPV4_ADDR_ADDR(SRC_IPV4_ADDR_ADDR), .DST_IPV4_ADDR_ADDR(DST_IPV4_ADDR_ADDR),
        .TCP_SRC_PORT_ADDR(TCP_SRC_PORT_ADDR), .TCP_DST_PORT_ADDR(TCP_DST_PORT_ADDR),
        .ip_hdr_offset(ip_hdr_offset), .csum_en(csum_en),
        .pkt_header_out(pkt_header_out), .pkt_out_valid(pkt_out_valid),
        .pkt_out_accept(pkt_out_accept), .deparse_err(deparse_err), .csum_err(csum_err)
    );

    typedef struct {
        logic [7:0]      mask;
        logic [47:0]     dmac, smac;
        logic [11:0]     vlan;
        logic [5:0]      tos;
        logic [31:0]     sip, dip;
        logic [15:0]     sport, dport;
        logic [7:0][8:0] off;
        logic [8:0]      ip_off;
        logic            csum_en;
        logic [511:0]    hin;
        logic [511:0]    hexp;
        logic [7:0]      derr;
        logic            cerr;
        int              lat;
    } vec_t;

    localparam logic [159:0] IPV4_HDR = 160'h4500_0073_0000_4000_4011_0000_c0a8_0001_c0a8_00c7;

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t vecs[10];

    function automatic void check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Writes the low n bytes of val, MSB first, starting at byte off (byte 0 = bits 511:504).
    function automatic logic [511:0] put(input logic [511:0] h, input int off, input logic [159:0] val, input int n);
        logic [511:0] r;
        r = h;
        for (int i = 0; i < n; i++) r[511 - 8*(off+i) -: 8] = val[8*(n-1-i) +: 8];
        return r;
    endfunction

    function automatic vec_t blank();
        vec_t v;
        v.mask = '0; v.dmac = '0; v.smac = '0; v.vlan = '0; v.tos = '0;
        v.sip = '0; v.dip = '0; v.sport = '0; v.dport = '0; v.off = '0;
        v.ip_off = '0; v.csum_en = 1'b0; v.derr = '0; v.cerr = 1'b0; v.lat = 8;
        for (int i = 0; i < 16; i++) v.hin[32*i +: 32] = $urandom();
        v.hexp = v.hin;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        pkt_header_in = v.hin; of_mod_mask = v.mask;
        OF_DST_MAC_ADDR = v.dmac; OF_SRC_MAC_ADDR = v.smac; OF_VLAN_ID = v.vlan;
        OF_IPV4_TOS = v.tos; OF_SRC_IPV4_ADDR = v.sip; OF_DST_IPV4_ADDR = v.dip;
        OF_TCP_SRC_PORT = v.sport; OF_TCP_DST_PORT = v.dport;
        DST_MAC_ADDR_ADDR = v.off[0]; SRC_MAC_ADDR_ADDR = v.off[1]; VLAN_ID_ADDR = v.off[2];
        IPV4_TOS_ADDR = v.off[3]; SRC_IPV4_ADDR_ADDR = v.off[4]; DST_IPV4_ADDR_ADDR = v.off[5];
        TCP_SRC_PORT_ADDR = v.off[6]; TCP_DST_PORT_ADDR = v.off[7];
        ip_hdr_offset = v.ip_off; csum_en = v.csum_en;
    endtask

    task automatic run_vec(input vec_t v, input string tag, input bit early_oa, input int stall);
        int lat;
        bit acc_seen;
        @(negedge clk);
        drive(v);
        pkt_header_ready = 1'b1;
        pkt_out_accept   = early_oa;
        check({tag, "_idle_acc"}, 512'(pkt_header_accept), 512'(1));
        @(posedge clk); #1;
        pkt_header_ready = 1'b0;
        lat = 0;
        acc_seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (pkt_out_valid) begin
                lat = c;
                break;
            end
            if (pkt_header_accept) acc_seen = 1'b1;
        end
        check({tag, "_latency"}, 512'(lat), 512'(v.lat));
        check({tag, "_busy_acc"}, 512'(acc_seen), 512'(0));
        check({tag, "_hdr"}, pkt_header_out, v.hexp);
        check({tag, "_derr"}, 512'(deparse_err), 512'(v.derr));
        check({tag, "_cerr"}, 512'(csum_err), 512'(v.cerr));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            pkt_header_ready = 1'b1;
            pkt_header_in    = ~v.hin;
            pkt_out_accept   = 1'b0;
            @(posedge clk); #1;
            check({tag, "_stall_vld"}, 512'(pkt_out_valid), 512'(1));
            check({tag, "_stall_hdr"}, pkt_header_out, v.hexp);
            check({tag, "_stall_acc"}, 512'(pkt_header_accept), 512'(0));
        end
        @(negedge clk);
        pkt_header_ready = 1'b0;
        pkt_out_accept   = 1'b1;
        @(posedge clk); #1;
        check({tag, "_ret_acc"}, 512'(pkt_header_accept), 512'(1));
        check({tag, "_ret_vld"}, 512'(pkt_out_valid), 512'(0));
        pkt_out_accept = 1'b0;
    endtask

    initial begin
        // 0: pass-through
        vecs[0] = blank();
        // 1: checksum over an unpatched IPv4 header at byte 14
        vecs[1] = blank();
        vecs[1].hin = put(vecs[1].hin, 14, IPV4_HDR, 20);
        vecs[1].ip_off = 9'd14; vecs[1].csum_en = 1'b1; vecs[1].lat = 19;
        vecs[1].hexp = put(vecs[1].hin, 24, 160'hb861, 2);
        // 2: patched destination address feeds the checksum
        vecs[2] = vecs[1];
        vecs[2].mask = 8'h20; vecs[2].dip = 32'hc0a800c8; vecs[2].off[5] = 9'd30;
        vecs[2].hexp = put(put(vecs[2].hin, 30, 160'hc0a800c8, 4), 24, 160'hb860, 2);
        // 3: field and IPv4 header both out of range
        vecs[3] = blank();
        vecs[3].mask = 8'h02; vecs[3].smac = 48'hdeadbeef0102; vecs[3].off[1] = 9'd60;
        vecs[3].ip_off = 9'd50; vecs[3].csum_en = 1'b1; vecs[3].derr = 8'h02; vecs[3].cerr = 1'b1;
        // 4: all eight fields, disjoint, with preserved PCP/CFI and ECN bits
        vecs[4] = blank();
        vecs[4].hin = put(put(vecs[4].hin, 14, 160'he5, 1), 17, 160'h57, 1);
        vecs[4].mask = 8'hff;
        vecs[4].dmac = 48'h112233445566; vecs[4].smac = 48'ha1a2a3a4a5a6;
        vecs[4].vlan = 12'habc; vecs[4].tos = 6'h2d;
        vecs[4].sip = 32'h0a000001; vecs[4].dip = 32'h0a000002;
        vecs[4].sport = 16'h1234; vecs[4].dport = 16'habcd;
        vecs[4].off = {9'd30, 9'd28, 9'd24, 9'd20, 9'd17, 9'd14, 9'd6, 9'd0};
        vecs[4].hexp = put(vecs[4].hin, 0, 160'h112233445566, 6);
        vecs[4].hexp = put(vecs[4].hexp, 6, 160'ha1a2a3a4a5a6, 6);
        vecs[4].hexp = put(vecs[4].hexp, 14, 160'heabc, 2);
        vecs[4].hexp = put(vecs[4].hexp, 17, 160'hb7, 1);
        vecs[4].hexp = put(vecs[4].hexp, 20, 160'h0a000001_0a000002_1234_abcd, 12);
        // 5: overlapping fields, higher index wins
        vecs[5] = blank();
        vecs[5].mask = 8'h83;
        vecs[5].dmac = 48'h010203040506; vecs[5].smac = 48'ha1a2a3a4a5a6; vecs[5].dport = 16'hbeef;
        vecs[5].off[0] = 9'd10; vecs[5].off[1] = 9'd12; vecs[5].off[7] = 9'd16;
        vecs[5].hexp = put(vecs[5].hin, 10, 160'h0102_a1a2a3a4_beef, 8);
        // 6: port one byte past the end, IPv4 header at the last legal offset
        vecs[6] = blank();
        vecs[6].hin = put(vecs[6].hin, 44, IPV4_HDR, 20);
        vecs[6].ip_off = 9'd44; vecs[6].csum_en = 1'b1; vecs[6].lat = 19;
        vecs[6].mask = 8'h40; vecs[6].sport = 16'hffff; vecs[6].off[6] = 9'd63; vecs[6].derr = 8'h40;
        vecs[6].hexp = put(vecs[6].hin, 54, 160'hb861, 2);
        // 7: port ending exactly on byte 63, patched into the last checksummed word
        vecs[7] = vecs[6];
        vecs[7].mask = 8'h80; vecs[7].dport = 16'h00c8; vecs[7].off[7] = 9'd62; vecs[7].derr = 8'h00;
        vecs[7].hexp = put(put(vecs[7].hin, 62, 160'h00c8, 2), 54, 160'hb860, 2);
        // 8: IPv4 header one byte beyond the last legal offset
        vecs[8] = vecs[6];
        vecs[8].mask = 8'h00; vecs[8].derr = 8'h00; vecs[8].ip_off = 9'd45;
        vecs[8].cerr = 1'b1; vecs[8].lat = 8; vecs[8].hexp = vecs[8].hin;
        // 9: checksum disabled leaves a stale checksum alone
        vecs[9] = blank();
        vecs[9].hin = put(put(vecs[9].hin, 14, IPV4_HDR, 20), 24, 160'h1234, 2);
        vecs[9].ip_off = 9'd14; vecs[9].hexp = vecs[9].hin;

        drive(vecs[0]);
        pkt_header_ready = 1'b0;
        pkt_out_accept   = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", 512'(pkt_header_accept), 512'(1));
        check("rst_vld", 512'(pkt_out_valid), 512'(0));
        check("rst_hdr", pkt_header_out, 512'(0));
        check("rst_errs", 512'({deparse_err, csum_err}), 512'(0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i), i[0], 0);

        // Held output with a competing header request
        run_vec(vecs[2], "stall", 1'b0, 5);

        // Reset while summing: flags, output and the in-flight header all go away
        @(negedge clk);
        drive(vecs[6]);
        pkt_header_ready = 1'b1;
        @(posedge clk); #1;
        pkt_header_ready = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("mid_derr", 512'(deparse_err), 512'(8'h40));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("csum_rst_acc", 512'(pkt_header_accept), 512'(1));
        check("csum_rst_vld", 512'(pkt_out_valid), 512'(0));
        check("csum_rst_hdr", pkt_header_out, 512'(0));
        check("csum_rst_errs", 512'({deparse_err, csum_err}), 512'(0));
        @(negedge clk);
        reset = 1'b0;
        begin
            bit vld_seen;
            vld_seen = 1'b0;
            repeat (25) begin
                @(posedge clk); #1;
                if (pkt_out_valid) vld_seen = 1'b1;
            end
            check("discarded", 512'(vld_seen), 512'(0));
        end
        run_vec(vecs[2], "after_rst", 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
